// File: rtl/avr_pkg.sv
// Shared AVR fetch/decode definitions: two-word opcode patterns and fetch FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package avr_pkg;

  localparam int INSTR_WIDTH = 16;

  // lds/sts carry a 16-bit data address in the second word
  localparam logic [INSTR_WIDTH-1:0] OP_LDS_STS_MASK  = 16'hFC0F;
  localparam logic [INSTR_WIDTH-1:0] OP_LDS           = 16'h9000;
  localparam logic [INSTR_WIDTH-1:0] OP_STS           = 16'h9200;
  // jmp/call carry the low 16 bits of the target in the second word
  localparam logic [INSTR_WIDTH-1:0] OP_JMP_CALL_MASK = 16'hFE0C;
  localparam logic [INSTR_WIDTH-1:0] OP_JMP_CALL      = 16'h940C;

  typedef enum logic {
    W1 = 1'b0,  // expecting the first word of an instruction
    W2 = 1'b1   // first word held in hi_q, expecting the second
  } fetch_state_t;

endpackage

// File: rtl/instr_len_decode.sv
// Classifies a 16-bit instruction word as one- or two-word (lds/sts/jmp/call).
// Latency: purely combinational.
// Backpressure: none; no state.
module instr_len_decode
  import avr_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] word,
  output logic                   is32
);

  logic is_lds_sts;
  logic is_jmp_call;

  assign is_lds_sts  = ((word & OP_LDS_STS_MASK) == OP_LDS) ||
                       ((word & OP_LDS_STS_MASK) == OP_STS);
  assign is_jmp_call = (word & OP_JMP_CALL_MASK) == OP_JMP_CALL;
  assign is32        = is_lds_sts || is_jmp_call;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives ROM address, assembles 1/2-word instructions, handles redirect and skip.
// Latency: instruction valid one cycle after its last word is at rom_data; one bubble per redirect.
// Backpressure: valid/ready output register; pc and FSM hold while a completed instruction cannot load.
module instr_fetch
  import avr_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  input  logic                   skip_req,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [INSTR_WIDTH-1:0] instr_ext,
  output logic                   instr_is32,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  if (DATA_WIDTH != INSTR_WIDTH) begin : g_bad_data_width
    $error("instr_fetch: DATA_WIDTH must be 16");
  end

  fetch_state_t           state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  pc_next;
  logic [ADDR_WIDTH-1:0]  pc_hi_q;
  logic [INSTR_WIDTH-1:0] hi_q;
  logic                   skip_pending;

  logic                   word_is32;
  logic                   first_of_two;
  logic                   completing;
  logic                   load_en;
  logic                   load_out;
  logic                   drop;
  logic                   word_take;
  logic [INSTR_WIDTH-1:0] cand_instr;
  logic [INSTR_WIDTH-1:0] cand_ext;
  logic [ADDR_WIDTH-1:0]  cand_pc;

  instr_len_decode u_len (
    .word (rom_data[INSTR_WIDTH-1:0]),
    .is32 (word_is32)
  );

  assign rom_addr = pc;
  assign pc_next  = pc + ADDR_WIDTH'(1);

  // Instruction completion and word-consume decisions for the current rom_data word.
  always_comb begin
    first_of_two = (state == W1) && word_is32;
    completing   = (state == W2) || !word_is32;
    load_en      = !instr_valid || instr_ready;
    drop         = completing && skip_pending;
    load_out     = completing && !skip_pending && load_en;
    word_take    = first_of_two || drop || load_out;
    cand_instr   = (state == W2) ? hi_q : rom_data[INSTR_WIDTH-1:0];
    cand_ext     = (state == W2) ? rom_data[INSTR_WIDTH-1:0] : '0;
    cand_pc      = (state == W2) ? pc_hi_q : pc;
  end

  // Program counter, FSM, skip tracking and the decode-facing output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      state        <= W1;
      hi_q         <= '0;
      pc_hi_q      <= '0;
      skip_pending <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_ext    <= '0;
      instr_is32   <= 1'b0;
      instr_pc     <= '0;
    end else if (redirect_valid) begin
      // the rom_data word of this cycle belongs to the old path and is discarded
      pc           <= redirect_addr;
      state        <= W1;
      skip_pending <= 1'b0;
      instr_valid  <= 1'b0;
    end else begin
      if (word_take) begin
        pc    <= pc_next;
        state <= first_of_two ? W2 : W1;
      end
      if (first_of_two) begin
        hi_q    <= rom_data[INSTR_WIDTH-1:0];
        pc_hi_q <= pc;
      end
      if (load_out) begin
        instr_valid <= 1'b1;
        instr       <= cand_instr;
        instr_ext   <= cand_ext;
        instr_is32  <= (state == W2);
        instr_pc    <= cand_pc;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
      // a skip already pending absorbs any further request
      if (drop) begin
        skip_pending <= 1'b0;
      end else if (skip_req && !skip_pending) begin
        skip_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed program scenarios plus randomized traffic.
// Latency: reference model predicts outputs every cycle.
// Backpressure: instr_ready driven directed and random.
module tb_instr_fetch;

  localparam int AW = 8;
  localparam int NW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          skip_req;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [15:0]   instr_ext;
  logic          instr_is32;
  logic [AW-1:0] instr_pc;

  logic [15:0]   rom [0:NW-1];

  int checks = 0;
  int errors = 0;

  // reference model: next instruction start, words of it already taken, skip flag, output register
  int            m_nxt;
  int            m_got;
  bit            m_skp;
  bit            m_v;
  logic [15:0]   m_i;
  logic [15:0]   m_e;
  bit            m_32;
  logic [AW-1:0] m_pc;

  always #5 clk = ~clk;

  // ROM registers the addressed word on the falling edge
  always @(negedge clk) rom_data <= rom[rom_addr];

  instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .RESET_VECTOR('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .skip_req       (skip_req),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_ext      (instr_ext),
    .instr_is32     (instr_is32),
    .instr_pc       (instr_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int instr_len(input logic [15:0] w);
    bit two;
    two = ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFC0F) == 16'h9200) ||
          ((w & 16'hFE0C) == 16'h940C);
    return two ? 2 : 1;
  endfunction

  task automatic model_edge();
    bit old_skp;
    bit acc;
    int len;
    if (!rst_n) begin
      m_nxt = 0; m_got = 0; m_skp = 0; m_v = 0;
      m_i = '0; m_e = '0; m_32 = 0; m_pc = '0;
    end else if (redirect_valid) begin
      m_nxt = int'(redirect_addr); m_got = 0; m_skp = 0; m_v = 0;
    end else begin
      old_skp = m_skp;
      acc     = m_v && instr_ready;
      len     = instr_len(rom[m_nxt]);
      if (m_got + 1 < len) begin
        m_got = m_got + 1;
        if (acc) m_v = 0;
      end else if (old_skp) begin
        m_skp = 0;
        m_nxt = (m_nxt + len) % NW;
        m_got = 0;
        if (acc) m_v = 0;
      end else if (!m_v || instr_ready) begin
        m_i   = rom[m_nxt];
        m_e   = (len == 2) ? rom[(m_nxt + 1) % NW] : 16'h0000;
        m_32  = (len == 2);
        m_pc  = m_nxt[AW-1:0];
        m_v   = 1;
        m_nxt = (m_nxt + len) % NW;
        m_got = 0;
      end
      if (skip_req && !old_skp) m_skp = 1;
    end
  endtask

  task automatic compare_all();
    chk("valid",    instr_valid, m_v);
    chk("rom_addr", rom_addr,    (m_nxt + m_got) % NW);
    chk("instr",    instr,       m_i);
    chk("ext",      instr_ext,   m_e);
    chk("is32",     instr_is32,  m_32);
    chk("pc",       instr_pc,    m_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_pc(input logic [AW-1:0] a, input int maxc, output bit found);
    found = 0;
    for (int i = 0; i < maxc && !found; i++) begin
      if (instr_valid && instr_pc == a) found = 1;
      else tick();
    end
    if (!found && instr_valid && instr_pc == a) found = 1;
  endtask

  task automatic hold_reset();
    rst_n = 0; redirect_valid = 0; skip_req = 0; instr_ready = 1;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int r;
    rst_n = 0; redirect_valid = 0; redirect_addr = '0; skip_req = 0; instr_ready = 1;
    for (int i = 0; i < NW; i++) rom[i] = 16'h0000;
    rom[0] = 16'hE813; rom[1] = 16'hBB19; rom[2] = 16'hE011;
    rom[3] = 16'hBB18; rom[4] = 16'hE31F; rom[5] = 16'hBB16;

    // reset state and linear program
    tick(); tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr",  rom_addr, 0);
    rst_n = 1;
    tick();
    chk("lat_valid", instr_valid, 1);
    chk("lat_instr", instr, 16'hE813);
    chk("lat_pc",    instr_pc, 0);
    repeat (5) tick();
    chk("lin_last_instr", instr, 16'hBB16);
    chk("lin_last_pc",    instr_pc, 5);

    // backpressure while address 1 is presented
    hold_reset();
    rst_n = 1;
    tick(); tick();
    chk("bp_start", instr_pc, 1);
    instr_ready = 0;
    repeat (3) begin
      tick();
      chk("bp_pc",   instr_pc, 1);
      chk("bp_addr", rom_addr, 2);
    end
    instr_ready = 1;
    tick();
    chk("bp_resume", instr_pc, 2);

    // two-word jump at address 2
    rom[2] = 16'h940C; rom[3] = 16'h0010;
    hold_reset();
    rst_n = 1;
    wait_pc(2, 8, found);
    chk("jmp_found", found, 1);
    chk("jmp_ext",   instr_ext, 16'h0010);
    chk("jmp_is32",  instr_is32, 1);
    tick();
    chk("jmp_next",  instr_pc, 4);

    // reset while waiting for the second word
    hold_reset();
    rst_n = 1;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (rom_addr == 3) found = 1;
      else tick();
    end
    chk("w2_reached", found, 1);
    rst_n = 0;
    tick();
    chk("w2rst_valid", instr_valid, 0);
    chk("w2rst_instr", instr, 0);
    chk("w2rst_pc",    instr_pc, 0);
    chk("w2rst_addr",  rom_addr, 0);
    tick();
    rst_n = 1;
    tick();
    chk("w2rst_first_v",  instr_valid, 1);
    chk("w2rst_first_pc", instr_pc, 0);

    // redirect together with skip: bubble, then target, no skip
    rom[2] = 16'hE011; rom[3] = 16'hBB18;
    rom[8'h40] = 16'hE0FF; rom[8'h41] = 16'hE0AA;
    hold_reset();
    rst_n = 1;
    wait_pc(3, 8, found);
    chk("redir_at3", found, 1);
    redirect_valid = 1; redirect_addr = 8'h40; skip_req = 1;
    tick();
    redirect_valid = 0; skip_req = 0;
    chk("redir_bubble", instr_valid, 0);
    tick();
    chk("redir_v",  instr_valid, 1);
    chk("redir_pc", instr_pc, 8'h40);
    tick();
    chk("redir_noskip", instr_pc, 8'h41);

    // skip over a two-word sts
    rom[4] = 16'h9300; rom[5] = 16'h0060;
    hold_reset();
    rst_n = 1;
    wait_pc(3, 8, found);
    chk("skip_at3", found, 1);
    skip_req = 1;
    tick();
    skip_req = 0;
    wait_pc(6, 6, found);
    chk("skip_to6", found, 1);

    // wrap-around: two-word at 255 takes its second word from 0
    rom[255] = 16'h940C;
    hold_reset();
    rst_n = 1;
    tick();
    redirect_valid = 1; redirect_addr = 8'hFF;
    tick();
    redirect_valid = 0;
    wait_pc(8'hFF, 6, found);
    chk("wrap_found", found, 1);
    chk("wrap_ext",   instr_ext, 16'hE813);
    tick();
    chk("wrap_next",  instr_pc, 1);

    // randomized traffic against the model
    rst_n = 0;
    for (int i = 0; i < NW; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rom[i] = 16'h940C | (16'($urandom) & 16'h01F3);
      else if (r == 1) rom[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
      else             rom[i] = 16'($urandom);
    end
    hold_reset();
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = AW'($urandom);
      skip_req       = ($urandom_range(0, 11) == 0);
      rst_n          = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
